// File: rtl/video_mode_pkg.sv
// Shared encodings for the display-mode sequencer and other frame-synchronised blocks.
package video_mode_pkg;

    localparam logic [1:0] MODE_COLOR = 2'b00;
    localparam logic [1:0] MODE_GREEN = 2'b01;
    localparam logic [1:0] MODE_AMBER = 2'b10;
    localparam logic [1:0] MODE_MONO  = 2'b11;

    localparam int unsigned FRAME_CNT_W = 4;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StWaitVs = 2'd1,
        StBlank  = 2'd2
    } vms_state_e;

endpackage

// File: rtl/vsync_edge_det.sv
// Flags the first active cycle of vertical sync.
module vsync_edge_det #(
    parameter bit VSYNC_POL = 1'b0
) (
    input  logic clk_vga_i,
    input  logic rst_i,
    input  logic vsync_i,
    output logic vs_start_o
);

    logic vs_q;

    // Reset to the inactive level so a sync already active at reset release still counts.
    always_ff @(posedge clk_vga_i) begin
        if (rst_i) begin
            vs_q <= ~VSYNC_POL;
        end else begin
            vs_q <= vsync_i;
        end
    end

    assign vs_start_o = (vsync_i == VSYNC_POL) && (vs_q != VSYNC_POL);

endmodule

// File: rtl/video_mode_sequencer.sv
// Arbitrates CPU/hotkey mode requests and commits them at vsync start, then blanks.
module video_mode_sequencer
    import video_mode_pkg::*;
#(
    parameter int unsigned BLANK_FRAMES = 2,
    parameter bit          VSYNC_POL    = 1'b0
) (
    input  logic       clk_vga_i,
    input  logic       rst_i,
    input  logic       vsync_i,
    input  logic       cpu_wr_i,
    input  logic [1:0] cpu_mode_i,
    input  logic       hk_cycle_i,
    output logic       cpu_ack_o,
    output logic [1:0] mode_o,
    output logic       blank_o,
    output logic [3:0] status_o
);

    logic                   vs_start;
    vms_state_e             state_q, state_d;
    logic [1:0]             mode_q, mode_d;
    logic [1:0]             next_mode_q, next_mode_d;
    logic                   pending_q, pending_d;
    logic                   blank_q, blank_d;
    logic                   cpu_ack_q, cpu_ack_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [1:0]             hk_base;

    vsync_edge_det #(
        .VSYNC_POL (VSYNC_POL)
    ) u_vsync_edge_det (
        .clk_vga_i  (clk_vga_i),
        .rst_i      (rst_i),
        .vsync_i    (vsync_i),
        .vs_start_o (vs_start)
    );

    assign hk_base = pending_q ? next_mode_q : mode_q;

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        next_mode_d = next_mode_q;
        pending_d   = pending_q;
        blank_d     = blank_q;
        cpu_ack_d   = 1'b0;
        frame_cnt_d = frame_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (pending_q) state_d = StWaitVs;
            end
            StWaitVs: begin
                if (vs_start) begin
                    pending_d = 1'b0;
                    if (next_mode_q == mode_q) begin
                        state_d = StIdle;
                    end else begin
                        mode_d = next_mode_q;
                        if (BLANK_FRAMES > 0) begin
                            blank_d     = 1'b1;
                            frame_cnt_d = FRAME_CNT_W'(BLANK_FRAMES);
                            state_d     = StBlank;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
            end
            StBlank: begin
                if (vs_start) begin
                    if (frame_cnt_q == FRAME_CNT_W'(1)) begin
                        blank_d     = 1'b0;
                        frame_cnt_d = '0;
                        state_d     = pending_q ? StWaitVs : StIdle;
                    end else begin
                        frame_cnt_d = frame_cnt_q - FRAME_CNT_W'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Requests come last so a new pending set beats a same-cycle commit clear.
        if (cpu_wr_i) begin
            next_mode_d = cpu_mode_i;
            pending_d   = 1'b1;
            cpu_ack_d   = 1'b1;
        end else if (hk_cycle_i) begin
            next_mode_d = hk_base + 2'd1;
            pending_d   = 1'b1;
        end
    end

    always_ff @(posedge clk_vga_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            mode_q      <= MODE_COLOR;
            next_mode_q <= MODE_COLOR;
            pending_q   <= 1'b0;
            blank_q     <= 1'b0;
            cpu_ack_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            next_mode_q <= next_mode_d;
            pending_q   <= pending_d;
            blank_q     <= blank_d;
            cpu_ack_q   <= cpu_ack_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign cpu_ack_o = cpu_ack_q;
    assign mode_o    = mode_q;
    assign blank_o   = blank_q;
    assign status_o  = {pending_q, blank_q, mode_q};

endmodule
